// File: rtl/student_rr_arbiter8.sv
// student_rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters
module student_or8way (
    input  logic [7:0] in,
    output logic       out
);
    assign out = |in;
endmodule

module student_rr_arbiter8 #(
    parameter int MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] grant_id,
    output logic       any_req
);
    typedef enum logic {IDLE, GRANTED} state_t;

    localparam logic [7:0] HMAX = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hcnt;
    logic [2:0] nxt;
    logic [7:0] others;
    logic [2:0] pick_req;
    logic [2:0] pick_oth;
    logic       preempt;

    student_or8way u_or (.in(req), .out(any_req));

    // first set bit of m searching upward from s with wrap
    function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] s);
        logic [2:0] p;
        pick = s;
        for (int i = 7; i >= 0; i--) begin
            p = s + 3'(i);
            if (m[p]) pick = p;
        end
    endfunction

    // candidate owners for fresh grant, release handoff and preemption
    always_comb begin
        nxt      = grant_id + 3'd1;
        others   = req & ~grant;
        pick_req = pick(req, state == IDLE ? ptr : nxt);
        pick_oth = pick(others, nxt);
        preempt  = (MAX_HOLD != 0) && (hcnt == HMAX) && (others != 8'd0);
    end

    // ownership sequencing: grant, hold, release or preempt
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 8'd0;
            grant_valid <= 1'b0;
            grant_id    <= 3'd0;
            ptr         <= 3'd0;
            hcnt        <= 8'd0;
        end else if (state == IDLE) begin
            if (any_req) begin
                state       <= GRANTED;
                grant       <= 8'd1 << pick_req;
                grant_valid <= 1'b1;
                grant_id    <= pick_req;
                hcnt        <= 8'd1;
            end
        end else if (!req[grant_id]) begin
            ptr <= nxt;
            if (any_req) begin
                grant    <= 8'd1 << pick_req;
                grant_id <= pick_req;
                hcnt     <= 8'd1;
            end else begin
                state       <= IDLE;
                grant       <= 8'd0;
                grant_valid <= 1'b0;
            end
        end else if (preempt) begin
            ptr      <= nxt;
            grant    <= 8'd1 << pick_oth;
            grant_id <= pick_oth;
            hcnt     <= 8'd1;
        end else begin
            hcnt <= (hcnt == HMAX) ? hcnt : hcnt + 8'd1;
        end
    end
endmodule
